// File: rtl/rf_writeback.sv
// rf_writeback: register-file write-port initiator.
// Merges never-stalled ALU results with long-latency results (load, mult/div)
// that queue in a small FIFO, and offers a forwarding lookup over the pending
// writes so decode can see values that have not reached the register file yet.
module rf_writeback #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   alu_valid,
    input  logic [4:0]             alu_rd,
    input  logic [WIDTH-1:0]       alu_data,
    input  logic                   lr_valid,
    output logic                   lr_ready,
    input  logic [4:0]             lr_rd,
    input  logic [WIDTH-1:0]       lr_data,
    output logic                   wE,
    output logic [4:0]             rW,
    output logic [WIDTH-1:0]       busW,
    input  logic [4:0]             fwd_rs,
    output logic                   fwd_hit,
    output logic [WIDTH-1:0]       fwd_data,
    output logic [$clog2(DEPTH):0] pending
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // FIFO storage: destination, data and a valid bit that a younger ALU
    // write to the same register can clear (squash) while the entry waits.
    logic [4:0]       rd_q   [DEPTH];
    logic [4:0]       rd_d   [DEPTH];
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Registered write port.
    logic             we_q, we_d;
    logic [4:0]       rw_q, rw_d;
    logic [WIDTH-1:0] busw_q, busw_d;

    logic alu_wr;
    logic push;
    logic pop;

    // Ready comes straight from the registered occupancy, so a pop in the
    // same cycle never opens a slot for a push when the FIFO is full.
    assign lr_ready = (count_q < CNT_W'(DEPTH));
    assign pending  = count_q;
    assign wE       = we_q;
    assign rW       = rw_q;
    assign busW     = busw_q;

    // Decode this cycle's port owner and FIFO push/pop.
    always_comb begin
        alu_wr = alu_valid && (alu_rd != 5'd0);
        push   = lr_valid && lr_ready && (lr_rd != 5'd0);
        // Any ALU result, even to r0, holds the FIFO head for this cycle.
        pop    = !alu_valid && (count_q != '0);
    end

    // Next-state for the write port, FIFO contents, pointers and count.
    always_comb begin
        // NOTE: every output of this block is defaulted first so no path
        // leaves a variable unassigned, which would infer a latch.
        rd_d     = rd_q;
        data_d   = data_q;
        vld_d    = vld_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        we_d     = 1'b0;
        rw_d     = rw_q;
        busw_d   = busw_q;

        if (alu_wr) begin
            we_d   = 1'b1;
            rw_d   = alu_rd;
            busw_d = alu_data;
            // The ALU result is youngest: older queued writes to the same
            // register must never land after it.
            for (int i = 0; i < DEPTH; i++) begin
                if (rd_q[i] == alu_rd) begin
                    vld_d[i] = 1'b0;
                end
            end
        end else if (pop) begin
            // A squashed head still consumes its slot, with the enable low.
            we_d            = vld_q[rd_ptr_q];
            rw_d            = rd_q[rd_ptr_q];
            busw_d          = data_q[rd_ptr_q];
            vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = rd_ptr_q + PTR_W'(1);
        end

        if (push) begin
            rd_d[wr_ptr_q]   = lr_rd;
            data_d[wr_ptr_q] = lr_data;
            // Same-cycle ALU write to this register wins, so enqueue dead.
            vld_d[wr_ptr_q]  = !(alu_wr && (alu_rd == lr_rd));
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end

        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // Control state: pointers, count, valid bits and the write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            vld_q    <= '0;
            we_q     <= 1'b0;
            rw_q     <= 5'd0;
            busw_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge values, independent of block order.
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            vld_q    <= vld_d;
            we_q     <= we_d;
            rw_q     <= rw_d;
            busw_q   <= busw_d;
        end
    end

    // FIFO payload storage.
    // NOTE: the payload is deliberately not reset; an entry is only read
    // once its valid bit and the count say it was written after reset.
    always_ff @(posedge clk) begin
        rd_q   <= rd_d;
        data_q <= data_d;
    end

    // Forwarding lookup: newest valid FIFO entry wins, output stage is last.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx      = '0;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if (fwd_rs != 5'd0) begin
            if (we_q && (rw_q == fwd_rs)) begin
                fwd_hit  = 1'b1;
                fwd_data = busw_q;
            end
            // Walk oldest to newest so a later match overrides an earlier one.
            for (int i = 0; i < DEPTH; i++) begin
                idx = rd_ptr_q + PTR_W'(i);
                if ((CNT_W'(i) < count_q) && vld_q[idx] && (rd_q[idx] == fwd_rs)) begin
                    fwd_hit  = 1'b1;
                    fwd_data = data_q[idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_rf_writeback.sv
// Self-checking bench for rf_writeback: a queue-based reference model is
// compared against the DUT every cycle, and directed scenarios pin the model
// with hand-computed values.
module tb_rf_writeback;

    localparam int DEPTH = 4;
    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             alu_valid = 1'b0;
    logic [4:0]       alu_rd = '0;
    logic [WIDTH-1:0] alu_data = '0;
    logic             lr_valid = 1'b0;
    logic             lr_ready;
    logic [4:0]       lr_rd = '0;
    logic [WIDTH-1:0] lr_data = '0;
    logic             wE;
    logic [4:0]       rW;
    logic [WIDTH-1:0] busW;
    logic [4:0]       fwd_rs = '0;
    logic             fwd_hit;
    logic [WIDTH-1:0] fwd_data;
    logic [2:0]       pending;

    int n_checks = 0;
    int n_errors = 0;

    rf_writeback #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .lr_valid(lr_valid), .lr_ready(lr_ready), .lr_rd(lr_rd), .lr_data(lr_data),
        .wE(wE), .rW(rW), .busW(busW),
        .fwd_rs(fwd_rs), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
        .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        bit          valid;
    } ent_t;

    ent_t        mq[$];
    bit          m_we = 1'b0;
    logic [4:0]  m_rw = '0;
    logic [31:0] m_busw = '0;
    ent_t        m_new, m_head;
    bit          m_push;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_we = 1'b0;
            m_rw = '0;
            m_busw = '0;
        end else begin
            m_push = lr_valid && (mq.size() < DEPTH) && (lr_rd != 0);
            m_new = '{rd: lr_rd, data: lr_data,
                      valid: !(alu_valid && alu_rd == lr_rd)};
            if (alu_valid) begin
                if (alu_rd != 0) begin
                    m_we = 1'b1;
                    m_rw = alu_rd;
                    m_busw = alu_data;
                    foreach (mq[k]) if (mq[k].rd == alu_rd) mq[k].valid = 1'b0;
                end else begin
                    m_we = 1'b0;
                end
            end else if (mq.size() > 0) begin
                m_head = mq.pop_front();
                m_we = m_head.valid;
                m_rw = m_head.rd;
                m_busw = m_head.data;
            end else begin
                m_we = 1'b0;
            end
            if (m_push) mq.push_back(m_new);
        end
    end

    bit          e_hit;
    logic [31:0] e_fdata;

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("wE", wE, m_we);
        check("rW", rW, m_rw);
        check("busW", busW, m_busw);
        check("pending", pending, mq.size());
        check("lr_ready", lr_ready, mq.size() < DEPTH);
        e_hit = 1'b0;
        e_fdata = '0;
        if (fwd_rs != 0) begin
            for (int k = mq.size() - 1; k >= 0; k--) begin
                if (!e_hit && mq[k].valid && mq[k].rd == fwd_rs) begin
                    e_hit = 1'b1;
                    e_fdata = mq[k].data;
                end
            end
            if (!e_hit && m_we && m_rw == fwd_rs) begin
                e_hit = 1'b1;
                e_fdata = m_busw;
            end
        end
        check("fwd_hit", fwd_hit, e_hit);
        check("fwd_data", fwd_data, e_fdata);
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input bit av, input logic [4:0] ar, input logic [31:0] ad,
                         input bit lv, input logic [4:0] lrd, input logic [31:0] ld);
        alu_valid = av; alu_rd = ar; alu_data = ad;
        lr_valid = lv; lr_rd = lrd; lr_data = ld;
    endtask

    initial begin
        #1 rst = 1'b1;
        step();
        step();
        check("rst_wE", wE, 0);
        check("rst_pending", pending, 0);
        check("rst_ready", lr_ready, 1);
        rst = 1'b0;
        step();

        // Latency and ALU priority.
        drive(1, 8, 32'h11, 0, 0, 0);
        step();
        check("lat_c1_wE", wE, 1);
        check("lat_c1_rW", rW, 8);
        drive(1, 9, 32'h22, 1, 10, 32'h33);
        step();
        check("lat_c2_rW", rW, 9);
        check("lat_c2_pending", pending, 1);
        drive(0, 0, 0, 0, 0, 0);
        step();
        check("lat_c3_rW", rW, 10);
        check("lat_c3_busW", busW, 32'h33);
        check("lat_c3_pending", pending, 0);
        step();
        check("lat_idle_wE", wE, 0);
        check("lat_idle_rW_hold", rW, 10);

        // Full and wrap-around, three rounds.
        for (int rep = 0; rep < 3; rep++) begin
            for (int j = 0; j < 4; j++) begin
                drive(1, 3, rep, 1, 5'(4 + j), 32'(32'h100 * rep + j));
                step();
            end
            check("full_pending", pending, 4);
            check("full_ready", lr_ready, 0);
            drive(1, 3, rep, 1, 9, 32'hDEAD);
            step();
            check("full_hold_pending", pending, 4);
            drive(0, 0, 0, 0, 0, 0);
            for (int j = 0; j < 4; j++) begin
                step();
                check("drain_wE", wE, 1);
                check("drain_rW", rW, 4 + j);
                check("drain_busW", busW, 32'h100 * rep + j);
            end
            check("drain_pending", pending, 0);
        end

        // Squash of a queued entry by a later ALU write.
        drive(1, 1, 1, 1, 12, 32'hAA);
        step();
        check("sq_pending", pending, 1);
        drive(1, 12, 32'hBB, 0, 0, 0);
        step();
        check("sq_alu_rW", rW, 12);
        check("sq_alu_busW", busW, 32'hBB);
        drive(0, 0, 0, 0, 0, 0);
        step();
        check("sq_pop_wE", wE, 0);
        check("sq_pop_pending", pending, 0);
        // Same-cycle squash.
        drive(1, 12, 32'hBB, 1, 12, 32'hCC);
        step();
        check("sq2_busW", busW, 32'hBB);
        check("sq2_pending", pending, 1);
        drive(0, 0, 0, 0, 0, 0);
        step();
        check("sq2_pop_wE", wE, 0);
        check("sq2_pop_pending", pending, 0);

        // Forwarding: newest of two r5 entries.
        drive(1, 1, 2, 1, 5, 1);
        step();
        drive(1, 1, 3, 1, 5, 2);
        step();
        drive(1, 1, 4, 0, 0, 0);
        fwd_rs = 5;
        #1;
        check("fwd5_hit", fwd_hit, 1);
        check("fwd5_data", fwd_data, 2);
        fwd_rs = 0;
        drive(1, 1, 4, 1, 0, 32'h55);
        #1;
        check("fwd0_hit", fwd_hit, 0);
        check("fwd0_data", fwd_data, 0);
        step();
        check("r0_push_pending", pending, 2);

        // ALU rd=0 with non-empty FIFO: no write, no pop.
        drive(1, 0, 32'h77, 0, 0, 0);
        step();
        check("alu_r0_wE", wE, 0);
        check("alu_r0_pending", pending, 2);
        drive(0, 0, 0, 0, 0, 0);
        fwd_rs = 5;
        step();
        check("pop5a_rW", rW, 5);
        check("pop5a_busW", busW, 1);
        step();
        check("pop5b_busW", busW, 2);
        check("pop5b_pending", pending, 0);
        check("fwd_out_hit", fwd_hit, 1);
        check("fwd_out_data", fwd_data, 2);
        step();
        check("fwd_none_hit", fwd_hit, 0);
        fwd_rs = 0;

        // Reset mid-stream.
        drive(1, 1, 5, 1, 20, 32'h20);
        step();
        drive(1, 1, 6, 1, 21, 32'h21);
        step();
        drive(1, 1, 7, 1, 22, 32'h22);
        step();
        check("mid_pending", pending, 3);
        rst = 1'b1;
        #1;
        check("mid_rst_pending", pending, 0);
        check("mid_rst_wE", wE, 0);
        check("mid_rst_ready", lr_ready, 1);
        drive(0, 0, 0, 0, 0, 0);
        step();
        rst = 1'b0;
        for (int j = 0; j < 4; j++) begin
            step();
            check("post_rst_wE", wE, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rf_writeback.md
Name: rf_writeback

Overview:
- Write-port initiator for the 32x32 register file.
- Merges two result sources onto the single write port (wE/rW/busW):
  - single-cycle ALU results, which are never stalled;
  - long-latency results (load, mult/div), which use a valid/ready handshake.
- Long-latency results wait in a small FIFO until the write port is free.
- Provides a forwarding lookup so decode can read values that are pending but not yet written.

Parameters:
- DEPTH, 4: FIFO entries; power of two, at least 2.
- WIDTH, 32: data width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- alu_valid  in  1  ALU result present this cycle.
- alu_rd  in  5  ALU destination register.
- alu_data  in  WIDTH  ALU result.
- lr_valid  in  1  long-latency result offered.
- lr_ready  out  1  FIFO can accept; lr_ready = (count < DEPTH), driven from registered count.
- lr_rd  in  5  long-latency destination register.
- lr_data  in  WIDTH  long-latency result.
- wE  out  1  register-file write enable (registered).
- rW  out  5  register-file write address (registered).
- busW  out  WIDTH  register-file write data (registered).
- fwd_rs  in  5  forwarding query register.
- fwd_hit  out  1  a pending write to fwd_rs exists.
- fwd_data  out  WIDTH  newest pending value for fwd_rs.
- pending  out  log2(DEPTH)+1  FIFO occupancy, valid and squashed entries both counted.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - wE=0, rW=0, busW=0.
  - Read/write pointers=0, count=0, all entry valid bits=0.
  - All queued results are discarded.
  - lr_ready=1 after reset.
- Accept:
  - A long-latency result is accepted on a rising edge with lr_valid and lr_ready both high.
  - Accepted with lr_rd=0: the handshake completes but nothing is enqueued.
  - Otherwise {rd, data, valid=1} is written at the write pointer.
- Port arbitration, once per cycle, evaluated on the current inputs and registered into wE/rW/busW at the next edge (one-cycle latency):
  1. alu_valid and alu_rd != 0: wE=1, rW=alu_rd, busW=alu_data.
  2. alu_valid and alu_rd = 0: wE=0, and the FIFO does not pop this cycle.
  3. No ALU result and FIFO non-empty: pop the head. wE=head.valid, rW=head.rd, busW=head.data. A squashed head consumes the slot with wE=0.
  4. Otherwise wE=0; rW and busW hold their previous values.
- Ordering (ALU result is always youngest):
  - An ALU write to register r (r != 0) clears the valid bit of every FIFO entry with rd=r.
  - A long-latency result to r accepted in the same cycle as an ALU write to r is enqueued already squashed (valid=0).
- Simultaneous push and pop in one cycle:
  - Allowed; count is unchanged.
  - When full, lr_ready=0 blocks the push even if a pop occurs that cycle.
- Pointers wrap modulo DEPTH. count never exceeds DEPTH and never underflows.
- Forwarding (combinational):
  - If fwd_rs = 0: fwd_hit=0, fwd_data=0.
  - Otherwise search valid FIFO entries from newest to oldest. The first entry with rd=fwd_rs gives the hit.
  - If no FIFO entry matches, use the output stage when wE=1 and rW=fwd_rs.
  - With no hit, fwd_data=0.
- ALU results are never stalled or queued. The producer must not depend on lr_ready for the ALU path.

Test Plan:
- Reset mid-stream:
  - Stimulus: enqueue 3 entries, then assert rst for 1 cycle.
  - Response: pending=0, wE=0, lr_ready=1. No write appears afterwards.
- Latency and ALU priority:
  - Stimulus: ALU r8=0x11 in cycle 0. In cycle 1, ALU r9=0x22 together with a long-latency result r10=0x33.
  - Response:
    - cycle 1: wE=1, rW=8.
    - cycle 2: rW=9.
    - cycle 3: rW=10, busW=0x33.
    - pending peaks at 1.
- Full and wrap-around:
  - Stimulus: keep alu_valid high with r3 while pushing 4 long-latency results r4..r7.
  - Response:
    - After 4 accepts, lr_ready=0 and a 5th offer holds.
    - Drop alu_valid: writes r4, r5, r6, r7 on consecutive cycles.
    - Repeat 3 times so the pointers wrap; order is preserved.
- Squash:
  - Stimulus: enqueue r12=0xAA while stalled, then ALU r12=0xBB.
  - Response: r12 is written 0xBB once. The later FIFO slot pops with wE=0.
  - Also: a same-cycle long-latency r12 result with ALU r12 gives the same outcome.
- Forwarding:
  - Stimulus: FIFO holds r5=1 then r5=2.
  - Response: fwd_rs=5 gives fwd_hit=1, fwd_data=2.
  - fwd_rs=0 gives fwd_hit=0, even with a pending r0 push (which is discarded).
- Register 0:
  - Stimulus: ALU rd=0 with a non-empty FIFO.
  - Response: wE=0 in the next cycle and the FIFO does not pop.
  - Long-latency rd=0: handshake accepted, pending unchanged.
